ram_arbiter: RTL

Two-port arbiter that shares one single-port synchronous RAM (one access per cycle, read data one cycle after address) between two requesters, e.g. instruction fetch and data access. It selects one request per cycle, drives the RAM address, data and write-enable, and returns read data with a per-port valid strobe aligned to the RAM's one-cycle read latency. A lock input lets a requester hold the RAM across consecutive cycles for multi-word sequences.

---
 rtl/ram_arbiter_pkg.sv | 15 +
 rtl/ram_arb_pick.sv | 19 +
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Holds the FSM state encoding and the default data/address widths so that the
// CPU top level and the RAM instance agree with the arbiter on them.
package ram_arbiter_pkg;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefAddrWidth = 8;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational tie-break for the RAM arbiter.
// Ports:
//   req_i       - request bits, [0] = port 0, [1] = port 1
//   prefer_p1_i - on a tie, grant port 1 instead of port 0
//   gnt_o       - one-hot (or zero) grant
module ram_arb_pick (
  input  logic [1:0] req_i,
  input  logic       prefer_p1_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prefer_p1_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM (one-cycle read latency).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/lock   - requester N access; lock keeps the grant afterwards
//   pN_gnt                      - combinational grant; access completes at the edge
//   pN_rvalid                   - registered; rdata holds port N's read data this cycle
//   rdata                       - ram_dout passed straight through
//   ram_addr/ram_din/ram_we     - RAM command from the granted port
//   ram_dout                    - RAM read data
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise
// port 0 always wins ties and there is no pointer register.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0]      p0_wdata,
  input  logic                  p0_lock,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0]      p1_wdata,
  input  logic                  p1_lock,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_dout
);

  arb_state_e state_q, state_d;
  logic [1:0] req;
  logic [1:0] we_vec;
  logic [1:0] arb_gnt;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;
  logic       use_arb;
  logic       prefer_p1;
  logic [1:0] rvalid_q, rvalid_d;

  assign req    = {p1_req, p0_req};
  assign we_vec = {p1_we, p0_we};

  ram_arb_pick u_pick (
    .req_i       (req),
    .prefer_p1_i (prefer_p1),
    .gnt_o       (arb_gnt)
  );

  // Next state and grant. A locked owner that drops req hands the cycle back to
  // normal arbitration, so the other port is not stalled for a bubble.
  always_comb begin
    state_d = state_q;
    gnt_raw = 2'b00;
    use_arb = 1'b0;
    unique case (state_q)
      StLock0: begin
        if (p0_req) begin
          gnt_raw = 2'b01;
          if (!p0_lock) state_d = StArb;
        end else begin
          use_arb = 1'b1;
        end
      end
      StLock1: begin
        if (p1_req) begin
          gnt_raw = 2'b10;
          if (!p1_lock) state_d = StArb;
        end else begin
          use_arb = 1'b1;
        end
      end
      default: use_arb = 1'b1;
    endcase
    if (use_arb) begin
      gnt_raw = arb_gnt;
      state_d = StArb;
      if (arb_gnt[0] && p0_lock) begin
        state_d = StLock0;
      end else if (arb_gnt[1] && p1_lock) begin
        state_d = StLock1;
      end
    end
  end

  // No grant (and hence no write) may escape while reset is held.
  assign gnt = rst_n ? gnt_raw : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic prefer_p1_q, prefer_p1_d;

  // Every accepted access (including locked ones) makes the other port preferred.
  always_comb begin
    prefer_p1_d = prefer_p1_q;
    if (|gnt) prefer_p1_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_p1_q <= 1'b0;
    end else begin
      prefer_p1_q <= prefer_p1_d;
    end
  end

  assign prefer_p1 = prefer_p1_q;
`else
  assign prefer_p1 = 1'b0;
`endif

  // Read owner bits line up with the RAM's one-cycle read latency.
  assign rvalid_d = gnt & req & ~we_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign rdata     = ram_dout;

  // Port 0 drives the RAM bus whenever port 1 is not granted.
  assign ram_addr = gnt[1] ? p1_addr  : p0_addr;
  assign ram_din  = gnt[1] ? p1_wdata : p0_wdata;
  assign ram_we   = (gnt[0] & p0_we) | (gnt[1] & p1_we);

endmodule
